// File: rtl/reg_scoreboard_pkg.sv
// Shared processor constants for the register scoreboard.
// Register file geometry and default pending-counter width.
package reg_scoreboard_pkg;

    localparam int NUM_REGS  = 8;
    localparam int REG_ID_W  = 3;
    localparam int CNT_W_DEF = 2;

    typedef logic [REG_ID_W-1:0] regId_t;

endpackage

// File: rtl/dff.sv
// Generic register with asynchronous active-high clear.
// Building block for all scoreboard state.
module dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d each edge; clear immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/pend_ctr.sv
// Saturating pending-write counter for one register.
// Simultaneous inc and dec cancel; dec at zero flags underflow.
module pend_ctr #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero,
    output logic             max,
    output logic             underflow
);

    logic [CNT_W-1:0] cntNext;

    assign zero      = (cnt == '0);
    assign max       = (cnt == {CNT_W{1'b1}});
    assign underflow = dec & zero;

    // Net count change; never wraps in either direction
    always_comb begin
        cntNext = cnt;
        if (inc && !dec && !max) begin
            cntNext = cnt + CNT_W'(1);
        end else if (dec && !inc && !zero) begin
            cntNext = cnt - CNT_W'(1);
        end
    end

    dff #(.W(CNT_W)) uCnt (
        .clk (clk),
        .rst (rst),
        .d   (cntNext),
        .q   (cnt)
    );

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters.
// Stalls issue on RAW hazards or counter saturation.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issueEn,
    input  logic [2:0] issueReg,
    input  logic       wbEn,
    input  logic [2:0] wbReg,
    input  logic       rdAUse,
    input  logic [2:0] rdAReg,
    input  logic       rdBUse,
    input  logic [2:0] rdBReg,
    output logic       stall,
    output logic [7:0] busy,
    output logic       err
);

    logic [NUM_REGS-1:0] incVec;
    logic [NUM_REGS-1:0] decVec;
    logic [NUM_REGS-1:0] zeroVec;
    logic [NUM_REGS-1:0] maxVec;
    logic [NUM_REGS-1:0] underVec;
    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic                issueOk;
    logic                hazA;
    logic                hazB;
    logic                full;

    // Hazards look only at registered counts; no writeback bypass
    assign hazA  = rdAUse  & ~zeroVec[rdAReg];
    assign hazB  = rdBUse  & ~zeroVec[rdBReg];
    assign full  = issueEn &  maxVec[issueReg];
    assign stall = ~rst & (hazA | hazB | full);

    assign issueOk = issueEn & ~stall;
    assign busy    = ~zeroVec;

    for (genvar i = 0; i < NUM_REGS; i++) begin : gCtr
        assign incVec[i] = issueOk & (issueReg == REG_ID_W'(i));
        assign decVec[i] = wbEn    & (wbReg    == REG_ID_W'(i));

        pend_ctr #(.CNT_W(CNT_W)) uCtr (
            .clk       (clk),
            .rst       (rst),
            .inc       (incVec[i]),
            .dec       (decVec[i]),
            .cnt       (cnt[i]),
            .zero      (zeroVec[i]),
            .max       (maxVec[i]),
            .underflow (underVec[i])
        );
    end

    // Sticky error on any writeback to a register with nothing pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (|underVec) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard.
// Expected post-edge values are queued with each stimulus.
module tb_reg_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       issueEn;
    logic [2:0] issueReg;
    logic       wbEn;
    logic [2:0] wbReg;
    logic       rdAUse;
    logic [2:0] rdAReg;
    logic       rdBUse;
    logic [2:0] rdBReg;
    logic       stall;
    logic [7:0] busy;
    logic       err;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        string      tag;
        int         kind;
        logic [7:0] val;
    } exp_t;

    exp_t sbq[$];

    localparam int K_BUSY = 0;
    localparam int K_ERR  = 1;

    reg_scoreboard dut (
        .clk      (clk),
        .rst      (rst),
        .issueEn  (issueEn),
        .issueReg (issueReg),
        .wbEn     (wbEn),
        .wbReg    (wbReg),
        .rdAUse   (rdAUse),
        .rdAReg   (rdAReg),
        .rdBUse   (rdBUse),
        .rdBReg   (rdBReg),
        .stall    (stall),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [7:0] got,
                            input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pushExp(input string tag, input int kind,
                           input logic [7:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = val;
        sbq.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.kind == K_BUSY) checkVal(e.tag, busy, e.val);
            else checkVal(e.tag, {7'd0, err}, e.val);
        end
    endtask

    task automatic idle();
        issueEn = 0; issueReg = 0;
        wbEn    = 0; wbReg    = 0;
        rdAUse  = 0; rdAReg   = 0;
        rdBUse  = 0; rdBReg   = 0;
    endtask

    task automatic issue(input logic [2:0] r, input string tag,
                         input logic [7:0] expBusy);
        idle();
        issueEn = 1; issueReg = r;
        #1;
        checkVal({tag, "_stall"}, {7'd0, stall}, 8'd0);
        pushExp({tag, "_busy"}, K_BUSY, expBusy);
        tick();
    endtask

    task automatic wb(input logic [2:0] r, input string tag,
                      input logic [7:0] expBusy);
        idle();
        wbEn = 1; wbReg = r;
        pushExp({tag, "_busy"}, K_BUSY, expBusy);
        tick();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst = 1;
        issueEn = 1; issueReg = 3;
        rdAUse = 1; rdAReg = 3;
        #2;
        checkVal("rst_busy", busy, 8'h00);
        checkVal("rst_err", {7'd0, err}, 8'd0);
        checkVal("rst_stall", {7'd0, stall}, 8'd0);
        pushExp("rst_ignore_busy", K_BUSY, 8'h00);
        tick();
        rst = 0;
        idle();

        issue(3'd3, "r3_issue", 8'h08);

        idle();
        rdAUse = 1; rdAReg = 3;
        #1;
        checkVal("rawA_stall", {7'd0, stall}, 8'd1);
        wbEn = 1; wbReg = 3;
        #1;
        checkVal("rawA_wb_stall", {7'd0, stall}, 8'd1);
        pushExp("r3_wb_busy", K_BUSY, 8'h00);
        tick();
        wbEn = 0;
        #1;
        checkVal("rawA_clear_stall", {7'd0, stall}, 8'd0);

        issue(3'd5, "r5_i1", 8'h20);
        issue(3'd5, "r5_i2", 8'h20);
        issue(3'd5, "r5_i3", 8'h20);
        idle();
        issueEn = 1; issueReg = 5;
        #1;
        checkVal("r5_full_stall", {7'd0, stall}, 8'd1);
        pushExp("r5_full_busy", K_BUSY, 8'h20);
        tick();
        wb(3'd5, "r5_w1", 8'h20);
        wb(3'd5, "r5_w2", 8'h20);
        wb(3'd5, "r5_w3", 8'h00);
        pushExp("r5_noerr", K_ERR, 8'd0);
        idle();
        tick();

        issue(3'd2, "r2_issue", 8'h04);
        idle();
        issueEn = 1; issueReg = 2;
        wbEn = 1; wbReg = 2;
        #1;
        checkVal("r2_same_stall", {7'd0, stall}, 8'd0);
        pushExp("r2_same_busy", K_BUSY, 8'h04);
        tick();
        wb(3'd2, "r2_wb", 8'h00);
        pushExp("r2_noerr", K_ERR, 8'd0);
        idle();
        tick();

        issue(3'd4, "r4_issue", 8'h10);
        idle();
        issueEn = 1; issueReg = 0;
        wbEn = 1; wbReg = 4;
        pushExp("r0i_r4w_busy", K_BUSY, 8'h01);
        tick();
        wb(3'd0, "r0_wb", 8'h00);

        issue(3'd7, "r7_issue", 8'h80);
        idle();
        rdBUse = 1; rdBReg = 7;
        #1;
        checkVal("rawB_stall", {7'd0, stall}, 8'd1);
        rdBReg = 6;
        #1;
        checkVal("rawB_other_stall", {7'd0, stall}, 8'd0);
        wb(3'd7, "r7_wb", 8'h00);

        wb(3'd6, "r6_under", 8'h00);
        checkVal("r6_err", {7'd0, err}, 8'd1);
        idle();
        tick();
        checkVal("r6_err_sticky1", {7'd0, err}, 8'd1);
        tick();
        checkVal("r6_err_sticky2", {7'd0, err}, 8'd1);

        issue(3'd1, "r1_pend", 8'h02);
        issue(3'd7, "r7_pend", 8'h82);
        idle();
        #1;
        rst = 1;
        #1;
        checkVal("midrst_busy", busy, 8'h00);
        checkVal("midrst_err", {7'd0, err}, 8'd0);
        rst = 0;
        issue(3'd1, "post_rst_r1", 8'h02);
        pushExp("post_rst_err", K_ERR, 8'd0);
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 The block SHALL have parameter CNT_W, default 2, giving the pending-counter width per register; PEND_MAX = 2^CNT_W - 1.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port issueEn, input, 1 bit: an instruction writing register issueReg requests issue this cycle.
REQ-005 The block SHALL have port issueReg, input, 3 bits: destination register ID of the issuing instruction.
REQ-006 The block SHALL have port wbEn, input, 1 bit: a writeback to register wbReg completes this cycle.
REQ-007 The block SHALL have port wbReg, input, 3 bits: destination register ID being written back.
REQ-008 The block SHALL have ports rdAUse (input, 1 bit) and rdAReg (input, 3 bits): source operand A is used, with its register ID.
REQ-009 The block SHALL have ports rdBUse (input, 1 bit) and rdBReg (input, 3 bits): source operand B is used, with its register ID.
REQ-010 The block SHALL have port stall, output, 1 bit: the issuing instruction must hold this cycle.
REQ-011 The block SHALL have port busy, output, 8 bits: bit i = 1 when register i has a nonzero pending count.
REQ-012 The block SHALL have port err, output, 1 bit: sticky protocol-error flag.

Function
REQ-013 The block SHALL hold one CNT_W-bit pending counter per register 0..7.
REQ-014 stall SHALL be combinational from registered state only: (rdAUse & cnt[rdAReg]!=0) | (rdBUse & cnt[rdBReg]!=0) | (issueEn & cnt[issueReg]==PEND_MAX).
REQ-015 Same-cycle writeback SHALL NOT clear stall; there is no WB-to-read bypass.
REQ-016 An issue SHALL be accepted only when issueEn=1 and stall=0; an accepted issue increments cnt[issueReg] at the next edge.
REQ-017 wbEn=1 SHALL decrement cnt[wbReg] at the next edge, independent of stall.
REQ-018 An accepted issue and a writeback to the same register in the same cycle SHALL leave that count unchanged.
REQ-019 An accepted issue and a writeback to different registers in the same cycle SHALL both take effect.
REQ-020 A writeback to a register whose count is 0 SHALL leave the count at 0 and set err at the next edge.
REQ-021 An increment at PEND_MAX is unreachable because stall blocks it; counts SHALL never wrap.
REQ-022 err SHALL stay 1 until reset.
REQ-023 busy[i] SHALL equal (cnt[i]!=0), derived from registered state with zero latency.

Reset
REQ-024 On rst=1, all counts, busy and err SHALL clear to 0 immediately (asynchronously).
REQ-025 While rst=1, stall SHALL be 0 and issue/writeback inputs SHALL be ignored.
REQ-026 Reset asserted mid-operation SHALL discard all pending state; the first edge after deassertion SHALL act on the inputs present at that edge.

Structure
REQ-027 Constants NUM_REGS=8, REG_ID_W=3 and default CNT_W=2 SHALL live in the shared processor constants include.
REQ-028 The counter SHALL be a sub-module pend_ctr (inputs inc, dec; outputs cnt, zero, max, underflow), built from the codebase dff and instantiated 8 times.
REQ-029 Read-port multiplexing and error logic SHALL remain in reg_scoreboard.

Verification
REQ-030 After reset, issue r3 with no sources -> stall=0; next cycle busy=8'h08.
REQ-031 With r3 pending (count 1), rdAUse=1, rdAReg=3 -> stall=1; assert wbEn with wbReg=3 -> stall stays 1 that cycle and is 0 the next cycle; busy=8'h00.
REQ-032 Issue r5 three times -> count 3; a fourth issue to r5 -> stall=1 and count stays 3.
REQ-033 With r2 at count 1, accepted issue r2 plus wb r2 in the same cycle -> count stays 1; busy[2]=1.
REQ-034 wb r6 while its count is 0 -> err=1 next cycle and remains 1; busy[6]=0.
REQ-035 Pend r1 and r7, then pulse rst between edges -> busy=0 and err=0 immediately; the next issue r1 -> busy=8'h02.
